mul_seq: RTL and testbench

MUL_SEQ -- requirements
Module: mul_seq

---
 rtl/picomips_pkg.sv | 13 +
 rtl/mul_seq.sv | 139 +++++++++++++
 tb/tb_mul_seq.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/picomips_pkg.sv
// Shared definitions for the picoMIPS datapath blocks: multiplier FSM states and
// register-file address width.
package picomips_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_seq.sv
// Sequential signed shift-add multiplier: one partial product per cycle, with an
// integer or saturating Q1.(n-1) fractional result written to the register file.
module mul_seq
  import picomips_pkg::*;
#(
  parameter int unsigned n = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  frac,
  input  logic [n-1:0]          a,
  input  logic [n-1:0]          b,
  input  logic [REG_ADDR_W-1:0] dest,
  output logic                  busy,
  output logic                  done,
  output logic                  w,
  output logic [n-1:0]          Wdata,
  output logic [REG_ADDR_W-1:0] Waddr
);

  localparam int unsigned PW = 2 * n;
  localparam int unsigned CW = $clog2(n + 1);
  localparam logic [n-1:0] MIN_NEG = {1'b1, {(n-1){1'b0}}};
  localparam logic [n-1:0] MAX_POS = {1'b0, {(n-1){1'b1}}};

  state_t                  state_q, state_d;
  logic [PW-1:0]           acc_q, acc_d;
  logic [PW-1:0]           mcand_q, mcand_d;
  logic [n-1:0]            mplier_q, mplier_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    frac_q, frac_d;
  logic                    sat_q, sat_d;
  logic [REG_ADDR_W-1:0]   dest_q, dest_d;
  logic [n-1:0]            wdata_q, wdata_d;
  logic [REG_ADDR_W-1:0]   waddr_q, waddr_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    w_q, w_d;
  logic [PW-1:0]           pp;
  logic [PW-1:0]           product;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      frac_q   <= 1'b0;
      sat_q    <= 1'b0;
      dest_q   <= '0;
      wdata_q  <= '0;
      waddr_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      w_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      frac_q   <= frac_d;
      sat_q    <= sat_d;
      dest_q   <= dest_d;
      wdata_q  <= wdata_d;
      waddr_q  <= waddr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      w_q      <= w_d;
    end
  end

  // Status flags are computed for the next state so they come straight off flops.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    frac_d   = frac_q;
    sat_d    = sat_q;
    dest_d   = dest_q;
    wdata_d  = wdata_q;
    waddr_d  = waddr_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    w_d      = 1'b0;
    pp       = '0;
    product  = acc_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = BUSY;
          acc_d    = '0;
          mcand_d  = {{n{a[n-1]}}, a};
          mplier_d = b;
          count_d  = CW'(n);
          frac_d   = frac;
          sat_d    = (a == MIN_NEG) && (b == MIN_NEG);
          dest_d   = dest;
          busy_d   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        pp = mplier_q[0] ? mcand_q : '0;
        // The multiplier sign bit carries weight -2^(n-1), so the last step subtracts.
        product  = (count_q == CW'(1)) ? (acc_q - pp) : (acc_q + pp);
        acc_d    = product;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          w_d     = (dest_q != '0);
          waddr_d = dest_q;
          if (!frac_q)    wdata_d = product[n-1:0];
          else if (sat_q) wdata_d = MAX_POS;
          else            wdata_d = product[PW-2:n-1];
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign w     = w_q;
  assign Wdata = wdata_q;
  assign Waddr = waddr_q;

endmodule

// File: tb/tb_mul_seq.sv
// Bench for mul_seq (n=8): timeline-based reference model compared every cycle,
// plus directed operations with hand-computed results.
module tb_mul_seq;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       frac = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [4:0] dest = '0;
  logic       busy, done, w;
  logic [7:0] Wdata;
  logic [4:0] Waddr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_seq #(.n(N)) dut (
    .clk(clk), .reset(reset), .start(start), .frac(frac), .a(a), .b(b),
    .dest(dest), .busy(busy), .done(done), .w(w), .Wdata(Wdata), .Waddr(Waddr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result straight from integer arithmetic.
  function automatic logic [7:0] model_mul(input logic [7:0] x, input logic [7:0] y, input logic f);
    int p;
    logic [31:0] pv;
    p  = int'($signed(x)) * int'($signed(y));
    pv = p;
    if (!f) return pv[7:0];
    if (p == 16384) return 8'h7F;
    return pv[14:7];
  endfunction

  // Timeline model: an accepted start at edge e means busy in periods e..e+N-1 and
  // done in period e+N; period c is the interval following edge c.
  int         cyc = 0;
  bit         acc_valid = 1'b0;
  int         acc_edge = 0;
  logic [7:0] pa = '0, pb = '0;
  logic       pf = 1'b0;
  logic [4:0] pd = '0;
  logic [7:0] exp_wdata = '0;
  logic [4:0] exp_waddr = '0;

  function automatic bit in_busy(input int c);
    return acc_valid && (c >= acc_edge) && (c < acc_edge + N);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_valid = 1'b0;
      exp_wdata = '0;
      exp_waddr = '0;
      cyc       = 0;
    end else begin
      cyc++;
      if (acc_valid && cyc == acc_edge + N) begin
        exp_wdata = model_mul(pa, pb, pf);
        exp_waddr = pd;
      end
      if (start && !in_busy(cyc - 1)) begin
        acc_valid = 1'b1;
        acc_edge  = cyc;
        pa = a; pb = b; pf = frac; pd = dest;
      end
    end
  end

  always @(negedge clk) begin
    logic e_busy, e_done;
    e_busy = in_busy(cyc);
    e_done = acc_valid && (cyc == acc_edge + N);
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    chk("w", 32'(w), 32'(e_done && (exp_waddr != 0)));
    chk("Wdata", 32'(Wdata), 32'(exp_wdata));
    chk("Waddr", 32'(Waddr), 32'(exp_waddr));
  end

  // One isolated operation; operands are scrambled while busy to prove they were captured.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tf,
                        input logic [4:0] td, input logic [7:0] ew, input logic eww,
                        input bit no_wait, input string name);
    int lat = 0;
    int nb  = 0;
    if (!no_wait) @(negedge clk);
    a = ta; b = tb_v; frac = tf; dest = td; start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        lat = i;
        break;
      end
      if (busy) nb++;
      a = 8'($urandom); b = 8'($urandom); frac = 1'($urandom); dest = 5'($urandom);
    end
    chk({name, " latency"}, 32'(lat), 32'(N + 1));
    chk({name, " busy cycles"}, 32'(nb), 32'(N));
    chk({name, " Wdata"}, 32'(Wdata), 32'(ew));
    chk({name, " w"}, 32'(w), 32'(eww));
    chk({name, " Waddr"}, 32'(Waddr), 32'(td));
  endtask

  initial begin
    int  nd;
    bit  wseen;
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset w", 32'(w), 32'd0);
    chk("reset Wdata", 32'(Wdata), 32'd0);
    chk("reset Waddr", 32'(Waddr), 32'd0);

    // Start on the very first edge after reset release.
    reset = 1'b0;
    run_op(8'd3,   8'd5,   1'b0, 5'd4, 8'h0F, 1'b1, 1'b1, "3x5");
    run_op(8'hFF,  8'hFF,  1'b0, 5'd1, 8'h01, 1'b1, 1'b0, "m1xm1");
    run_op(8'h80,  8'h80,  1'b0, 5'd2, 8'h00, 1'b1, 1'b0, "minxmin int");
    run_op(8'h40,  8'h40,  1'b1, 5'd3, 8'h20, 1'b1, 1'b0, "half^2 frac");
    run_op(8'h80,  8'h80,  1'b1, 5'd5, 8'h7F, 1'b1, 1'b0, "minxmin sat");
    run_op(8'h80,  8'h40,  1'b1, 5'd6, 8'hC0, 1'b1, 1'b0, "m1xhalf frac");
    run_op(8'd2,   8'd2,   1'b0, 5'd0, 8'h04, 1'b0, 1'b0, "dest0");
    run_op(8'hF9,  8'd6,   1'b0, 5'd31, 8'hD6, 1'b1, 1'b0, "m7x6");

    // start held high; operand changes mid-BUSY only matter at the next capture.
    @(negedge clk);
    a = 8'd3; b = 8'd7; frac = 1'b0; dest = 5'd9; start = 1'b1;
    nd = 0;
    for (int i = 1; i <= 27; i++) begin
      @(negedge clk);
      if (done) nd++;
      if (i == 9)  chk("b2b first", 32'(Wdata), 32'h15);
      if (i == 18) chk("b2b second", 32'(Wdata), 32'h77);
      if (i == 27) chk("b2b third", 32'(Wdata), 32'h22);
      if (i == 4)  a = 8'h11;
      if (i == 13) b = 8'd2;
    end
    start = 1'b0;
    chk("b2b done count", 32'(nd), 32'd3);
    repeat (3) @(negedge clk);

    // Asynchronous reset three cycles into BUSY.
    a = 8'd5; b = 8'd6; dest = 5'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async busy", 32'(busy), 32'd0);
    chk("async done", 32'(done), 32'd0);
    chk("async w", 32'(w), 32'd0);
    chk("async Wdata", 32'(Wdata), 32'd0);
    chk("async Waddr", 32'(Waddr), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wseen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (w || done) wseen = 1'b1;
    end
    chk("no write after abort", 32'(wseen), 32'd0);

    run_op(8'd12, 8'd11, 1'b0, 5'd8, 8'h84, 1'b1, 1'b0, "after abort");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
